// File: rtl/baseline_pkg.sv
// Shared types and width helpers for the per-channel baseline estimator.
package baseline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        HOLD  = 2'd2
    } bl_state_t;

    // Window accumulator: summing 2^win_log2 samples grows the sum by win_log2 bits.
    function automatic int acc_width(input int in_w, input int win_log2);
        return in_w + win_log2;
    endfunction

    // Tracking difference needs one guard bit over the wider operand.
    function automatic int diff_width(input int in_w, input int base_w);
        return ((in_w > base_w) ? in_w : base_w) + 1;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrower: clamps a signed IN_W value into OUT_W bits.
module sat_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // Work width always exceeds OUT_W so the limits are representable.
    localparam int WW = (IN_W > OUT_W) ? IN_W : OUT_W + 1;

    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [WW-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end else begin
            return x[OUT_W-1:0];
        end
    endfunction

    logic signed [WW-1:0] wide;

    assign wide = WW'(din);
    assign dout = saturate(wide);

endmodule

// File: rtl/baseline_estimator.sv
// Per-channel baseline: averages 2^WIN_LOG2 valid samples, then holds the result.
// Optional EMA tracking in HOLD is enabled by defining BASELINE_TRACK_EN.
module baseline_estimator
    import baseline_pkg::*;
#(
    parameter int IN_W      = 72,
    parameter int BASE_W    = 50,
    parameter int WIN_LOG2  = 10,
    parameter int EMA_SHIFT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [IN_W-1:0]   feat_in,
    input  logic                     feat_valid,
    output logic signed [BASE_W-1:0] base_out,
    output logic                     base_valid,
    output logic                     busy
);

    localparam int ACC_W = acc_width(IN_W, WIN_LOG2);

    bl_state_t                 state;
    logic signed [ACC_W-1:0]   acc;
    logic [WIN_LOG2-1:0]       cnt;
    logic signed [BASE_W-1:0]  base_q;
    logic                      base_valid_q;
    logic                      busy_q;

    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   win_mean;
    logic signed [BASE_W-1:0]  win_sat;
    logic                      last_sample;

    assign acc_next    = acc + ACC_W'(feat_in);
    // Arithmetic shift floors the mean toward negative infinity.
    assign win_mean    = acc_next >>> WIN_LOG2;
    assign last_sample = &cnt;

    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (BASE_W)
    ) u_sat_win (
        .din  (win_mean),
        .dout (win_sat)
    );

`ifdef BASELINE_TRACK_EN
    localparam int DIFF_W = diff_width(IN_W, BASE_W);

    logic signed [DIFF_W-1:0] track_diff;
    logic signed [DIFF_W-1:0] track_step;
    logic signed [DIFF_W:0]   track_sum;
    logic signed [BASE_W-1:0] track_sat;

    assign track_diff = DIFF_W'(feat_in) - DIFF_W'(base_q);
    assign track_step = track_diff >>> EMA_SHIFT;
    assign track_sum  = (DIFF_W+1)'(base_q) + (DIFF_W+1)'(track_step);

    sat_narrow #(
        .IN_W  (DIFF_W + 1),
        .OUT_W (BASE_W)
    ) u_sat_track (
        .din  (track_sum),
        .dout (track_sat)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            base_q       <= '0;
            base_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= TRAIN;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                TRAIN: begin
                    // A restart wins over a coincident sample, which is dropped.
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (feat_valid) begin
                        if (last_sample) begin
                            state        <= HOLD;
                            base_q       <= win_sat;
                            base_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                            acc          <= '0;
                            cnt          <= '0;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + WIN_LOG2'(1);
                        end
                    end
                end
                HOLD: begin
                    // base_q keeps the previous result until the new window completes.
                    if (start) begin
                        state        <= TRAIN;
                        base_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        acc          <= '0;
                        cnt          <= '0;
                    end
`ifdef BASELINE_TRACK_EN
                    else if (feat_valid) begin
                        base_q <= track_sat;
                    end
`endif
                end
                default: begin
                    state        <= IDLE;
                    base_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign base_out   = base_q;
    assign base_valid = base_valid_q;
    assign busy       = busy_q;

endmodule
